// File: rtl/text_pkg.sv
// ------------------------------------------------------------------
// text_pkg: shared states, screen geometry and character codes.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package text_pkg;

  localparam int DEF_COLS = 70;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ------------------------------------------------------------------
// rr_arb2: two-way round-robin arbiter with a last-grant flop.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; requester 0 wins the first tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      last_grant <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vmem_text_arbiter.sv
// ------------------------------------------------------------------
// vmem_text_arbiter: keyboard/UART character writer with cursor and clear sweep.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module vmem_text_arbiter
  import text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_char,
  output logic        kbd_ready,
  input  logic        uart_valid,
  input  logic [7:0]  uart_char,
  output logic        uart_ready,
  input  logic        clr_req,
  output logic        busy,
  output logic        we,
  output logic [11:0] waddr,
  output logic [7:0]  wdata,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

  state_t      state;
  logic [11:0] clr_addr;
  logic [1:0]  grant;
  logic        arb_en;
  logic [7:0]  ch;
  logic [11:0] cur_addr;
  logic [4:0]  row_inc;
  logic [6:0]  adv_col;
  logic [4:0]  adv_row;
  logic [6:0]  back_col;
  logic [4:0]  back_row;

  // A same-cycle clear request pre-empts both requesters.
  assign arb_en = (state == ST_IDLE) && !clr_req;

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .en     (arb_en),
    .req    ({uart_valid, kbd_valid}),
    .grant  (grant)
  );

  assign kbd_ready  = grant[0];
  assign uart_ready = grant[1];
  assign ch         = grant[1] ? uart_char : kbd_char;
  assign cur_addr   = 12'(cur_row) * 12'(COLS) + 12'(cur_col);

  always_comb begin
    row_inc  = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
    adv_col  = (cur_col == LAST_COL) ? 7'd0 : cur_col + 7'd1;
    adv_row  = (cur_col == LAST_COL) ? row_inc : cur_row;
    back_col = (cur_col == 7'd0) ? LAST_COL : cur_col - 7'd1;
    back_row = (cur_col == 7'd0) ? cur_row - 5'd1 : cur_row;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cur_col  <= 7'd0;
      cur_row  <= 5'd0;
      we       <= 1'b0;
      waddr    <= 12'd0;
      wdata    <= 8'd0;
      busy     <= 1'b0;
      clr_addr <= 12'd0;
    end else begin
      we <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (clr_req) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= 12'd0;
          end else if (grant != 2'b00) begin
            if (is_printable(ch)) begin
              we      <= 1'b1;
              waddr   <= cur_addr;
              wdata   <= ch;
              cur_col <= adv_col;
              cur_row <= adv_row;
            end else if (ch == CH_LF) begin
              cur_col <= 7'd0;
              cur_row <= row_inc;
            end else if (ch == CH_BS && (cur_col != 7'd0 || cur_row != 5'd0)) begin
              // The previous cell is always one linear address below the cursor.
              we      <= 1'b1;
              waddr   <= cur_addr - 12'd1;
              wdata   <= CH_SPACE;
              cur_col <= back_col;
              cur_row <= back_row;
            end
          end
        end
        ST_CLEAR: begin
          we       <= 1'b1;
          waddr    <= clr_addr;
          wdata    <= CH_SPACE;
          clr_addr <= clr_addr + 12'd1;
          if (clr_addr == LAST_CELL) begin
            state   <= ST_IDLE;
            cur_col <= 7'd0;
            cur_row <= 5'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/vmem_text_arbiter.md
VMEM_TEXT_ARBITER -- requirements
Module: vmem_text_arbiter

Interface
REQ-001 The block SHALL have parameter COLS, default 70, meaning characters per text row.
REQ-002 The block SHALL have parameter ROWS, default 30, meaning text rows on screen.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 The block SHALL have port kbd_valid, input, 1, meaning the keyboard requester offers a character.
REQ-006 The block SHALL have port kbd_char, input, 8, meaning the keyboard ASCII code.
REQ-007 The block SHALL have port kbd_ready, output, 1, meaning the keyboard character is accepted this cycle.
REQ-008 The block SHALL have port uart_valid, input, 1, meaning the UART requester offers a character.
REQ-009 The block SHALL have port uart_char, input, 8, meaning the UART ASCII code.
REQ-010 The block SHALL have port uart_ready, output, 1, meaning the UART character is accepted this cycle.
REQ-011 The block SHALL have port clr_req, input, 1, meaning a single-cycle request to clear the screen.
REQ-012 The block SHALL have port busy, output, 1, meaning a clear sweep is in progress.
REQ-013 The block SHALL have port we, output, 1, meaning the text-buffer write strobe.
REQ-014 The block SHALL have port waddr, output, 12, meaning the write address, equal to row*COLS+col.
REQ-015 The block SHALL have port wdata, output, 8, meaning the character written.
REQ-016 The block SHALL have ports cur_col, output, 7, and cur_row, output, 5, meaning the cursor position.

Function
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 In IDLE, at most one ready SHALL be high per cycle; a transfer occurs when valid and ready are both high.
REQ-019 When exactly one requester is valid, that requester SHALL be granted.
REQ-020 When both requesters are valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-021 kbd_ready and uart_ready SHALL be combinational from state, the valids and the last-grant flop.
REQ-022 we, waddr and wdata SHALL be registered, appearing one cycle after acceptance; we SHALL be high for exactly one cycle per write.
REQ-023 Characters 0x20-0x7E SHALL be written at the cursor, then the cursor advances by one column.
REQ-024 When col=COLS-1, advancing SHALL set col to 0 and row to row+1; when row=ROWS-1, row SHALL wrap to 0 (no scroll).
REQ-025 Character 0x0A SHALL set col to 0 and advance row with the same wrap, and SHALL produce no write.
REQ-026 Character 0x08 SHALL move the cursor back one cell (col 0 goes to COLS-1 of row-1) and write 0x20 there.
REQ-027 Character 0x08 at (0,0) SHALL be accepted without a cursor change and without a write.
REQ-028 All other codes SHALL be accepted and ignored.
REQ-029 The cursor outputs SHALL update on the same edge that registers the corresponding write.
REQ-030 clr_req in IDLE SHALL enter CLEAR and take priority over any same-cycle request; no ready is asserted in that cycle.
REQ-031 In CLEAR, the block SHALL write 0x20 to addresses 0 through COLS*ROWS-1, one per cycle, with both readies low and busy high.
REQ-032 After the last clear write, the block SHALL return to IDLE with the cursor at (0,0).
REQ-033 clr_req asserted during CLEAR SHALL be ignored.

Reset
REQ-034 resetn low at a clock edge SHALL force IDLE, cursor (0,0), we=0, waddr=0, wdata=0, busy=0, and last-grant=UART, so the keyboard wins the first tie.
REQ-035 Reset during CLEAR SHALL abort the sweep immediately, with no further writes.

Structure
REQ-036 Package text_pkg SHALL hold the state enum, the COLS/ROWS defaults and the character-code constants (0x0A, 0x08, 0x20, 0x7E).
REQ-037 Two-way round-robin arbitration SHALL be a sub-module named rr_arb2.

Verification
REQ-038 Reset, then kbd sends 'A' (0x41) -> the next cycle has we=1, waddr=0, wdata=0x41; cursor=(1,0).
REQ-039 kbd and uart both valid continuously -> grants alternate: kbd, uart, kbd, ...; waddr increments 0, 1, 2, ...
REQ-040 Cursor at (69,29), then 'x' -> write at waddr=2099; cursor=(0,0).
REQ-041 0x08 at (0,1) -> write 0x20 at waddr=69; cursor=(69,0). Then 0x0A -> no write; cursor=(0,1).
REQ-042 clr_req with kbd_valid in the same cycle -> kbd_ready=0; 2100 consecutive writes of 0x20 to addresses 0-2099; busy high throughout; cursor=(0,0); kbd accepted afterwards.
REQ-043 resetn low at clear address 500 -> we=0 from the next cycle; state IDLE; cursor=(0,0).
